// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when the op issues; HI/LO update after a fixed latency.
module mdu_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        temp_hi;
  logic [31:0]        temp_lo;
  logic               commit_en;

  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] sdiv_q_mag;
  logic [31:0] sdiv_r_mag;
  logic [31:0] sdiv_q;
  logic [31:0] sdiv_r;
  logic [31:0] udiv_q;
  logic [31:0] udiv_r;
  logic [31:0] b_safe;
  logic [31:0] b_mag_safe;

  // Signed divide via magnitudes; a zero divisor is swapped for 1 since its result is discarded.
  always_comb begin
    mul_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u      = {32'b0, a} * {32'b0, b};
    a_mag      = a[31] ? 32'(-a) : a;
    b_mag      = b[31] ? 32'(-b) : b;
    b_safe     = (b == 32'd0) ? 32'd1 : b;
    b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
    sdiv_q_mag = a_mag / b_mag_safe;
    sdiv_r_mag = a_mag % b_mag_safe;
    sdiv_q     = (a[31] ^ b[31]) ? 32'(-sdiv_q_mag) : sdiv_q_mag;
    sdiv_r     = a[31] ? 32'(-sdiv_r_mag) : sdiv_r_mag;
    udiv_q     = a / b_safe;
    udiv_r     = a % b_safe;
  end

  // Issue/commit sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      temp_hi   <= '0;
      temp_lo   <= '0;
      commit_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                temp_hi   <= mul_s[63:32];
                temp_lo   <= mul_s[31:0];
                commit_en <= 1'b1;
                cnt       <= CNT_W'(MUL_CYCLES);
                busy      <= 1'b1;
                state     <= BUSY;
              end
              OP_MULTU: begin
                temp_hi   <= mul_u[63:32];
                temp_lo   <= mul_u[31:0];
                commit_en <= 1'b1;
                cnt       <= CNT_W'(MUL_CYCLES);
                busy      <= 1'b1;
                state     <= BUSY;
              end
              OP_DIV: begin
                temp_hi   <= sdiv_r;
                temp_lo   <= sdiv_q;
                commit_en <= (b != 32'd0);
                cnt       <= CNT_W'(DIV_CYCLES);
                busy      <= 1'b1;
                state     <= BUSY;
              end
              OP_DIVU: begin
                temp_hi   <= udiv_r;
                temp_lo   <= udiv_q;
                commit_en <= (b != 32'd0);
                cnt       <= CNT_W'(DIV_CYCLES);
                busy      <= 1'b1;
                state     <= BUSY;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (commit_en) begin
              hi <= temp_hi;
              lo <= temp_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed cases plus random ops against a longint arithmetic model.
module tb_mdu_unit;

  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_unit #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, p, q, r;
    longint unsigned pu;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    case (o)
      3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin pu = longint'(x) * longint'(y); m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd2: if (y != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
      3'd3: if (y != 32'd0) begin m_lo = x / y; m_hi = x % y; end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] old_hi, old_lo;
    int unsigned lat;
    old_hi = m_hi;
    old_lo = m_lo;
    lat = (o < 3'd2) ? MUL_LAT : DIV_LAT;
    issue(o, x, y);
    model(o, x, y);
    for (int i = 0; i < int'(lat); i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      chk({tag, "_hi_hold"}, hi, old_hi);
      chk({tag, "_lo_hold"}, lo, old_lo);
      @(posedge clk);
      #1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  task automatic run_single(input string tag, input logic [2:0] o, input logic [31:0] x);
    issue(o, x, 32'h0);
    model(o, x, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [31:0] rx, ry;
    logic [2:0]  ro;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_single("mthi", 3'd4, 32'h12345678);
    run_single("mtlo", 3'd5, 32'h9ABCDEF0);
    chk("mt_hi_const", hi, 32'h12345678);
    chk("mt_lo_const", lo, 32'h9ABCDEF0);

    run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3);
    chk("mult_neg_hi_const", hi, 32'hFFFFFFFF);
    chk("mult_neg_lo_const", lo, 32'hFFFFFFFA);
    @(posedge clk);
    #1;
    chk("mult_done_pulse", 32'(done), 32'd0);

    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hi_const", hi, 32'hFFFFFFFE);
    chk("multu_lo_const", lo, 32'h00000001);

    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    chk("div_neg_lo_const", lo, 32'hFFFFFFFD);
    chk("div_neg_hi_const", hi, 32'hFFFFFFFF);

    run_op("divu", 3'd3, 32'd7, 32'd2);
    chk("divu_lo_const", lo, 32'd3);
    chk("divu_hi_const", hi, 32'd1);

    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo_const", lo, 32'h80000000);
    chk("div_ovf_hi_const", hi, 32'h0);

    run_op("div_zero", 3'd2, 32'h12345678, 32'h0);
    chk("div_zero_lo_const", lo, 32'h80000000);
    chk("div_zero_hi_const", hi, 32'h0);

    // Starts while busy must be dropped, including MTLO.
    issue(3'd0, 32'd5, 32'd5);
    model(3'd0, 32'd5, 32'd5);
    chk("ign_busy0", 32'(busy), 32'd1);
    issue(3'd5, 32'h0000DEAD, 32'h0);
    chk("ign_busy1", 32'(busy), 32'd1);
    chk("ign_lo_hold", lo, 32'h80000000);
    issue(3'd3, 32'd100, 32'd7);
    chk("ign_busy2", 32'(busy), 32'd1);
    repeat (MUL_LAT - 2) begin
      @(posedge clk);
      #1;
    end
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_hi", hi, 32'h0);
    chk("ign_lo", lo, 32'd25);
    @(posedge clk);
    #1;
    chk("ign_no_divu", 32'(busy), 32'd0);

    // Asynchronous reset in the 4th busy cycle of a divide.
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      chk("arst_no_done", 32'(done), 32'd0);
    end

    // Back-to-back: second issue lands in the done cycle of the first.
    run_op("b2b_divu", 3'd3, 32'd100, 32'd7);
    run_op("b2b_multu", 3'd1, 32'd2, 32'd3);
    chk("b2b_hi_const", hi, 32'h0);
    chk("b2b_lo_const", lo, 32'd6);

    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'h0;
        1: ry = 32'hFFFFFFFF;
        2: ry = 32'd1;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rx = 32'h80000000;
      if (ro < 3'd4) run_op("rnd_op", ro, rx, ry);
      else run_single("rnd_single", ro, rx);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
